// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID-stage control decoder: opcode map, ALU
// operation classes, halt cause codes, FSM state encoding and funct legality
// helpers.
package ctrl_pkg;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // R-type funct7 values accepted by the rv32im_zbb datapath
  localparam logic [6:0] F7_BASE       = 7'b0000000;
  localparam logic [6:0] F7_ALT        = 7'b0100000;
  localparam logic [6:0] F7_MULDIV     = 7'b0000001;
  localparam logic [6:0] F7_ZBB_ZEXT   = 7'b0000100;
  localparam logic [6:0] F7_ZBB_MINMAX = 7'b0000101;
  localparam logic [6:0] F7_ZBB_ROT    = 7'b0110000;

  // ALU operation class handed to the EX-stage ALU control
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

  // Reason the pipeline is (or will be) stopped
  localparam logic [1:0] HALT_NONE    = 2'b00;
  localparam logic [1:0] HALT_ECALL   = 2'b01;
  localparam logic [1:0] HALT_EBREAK  = 2'b10;
  localparam logic [1:0] HALT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Width-independent part of the ID/EX control bundle
  typedef struct packed {
    logic       mem_to_reg;
    logic       rd_we;
    logic       alu_src_b;
    logic       branch;
    logic [1:0] alu_op;
    logic       rs1_in_use;
    logic       rs2_in_use;
    logic       pc_operand;
  } ctrl_t;

  // True for funct7 values that name an implemented R-type operation
  function automatic logic rtype_funct7_legal(input logic [6:0] f7);
    case (f7)
      F7_BASE, F7_ALT, F7_MULDIV,
      F7_ZBB_ZEXT, F7_ZBB_MINMAX, F7_ZBB_ROT: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  // True for load widths the datapath supports; LD/LWU exist only on RV64
  function automatic logic load_funct3_legal(input logic [2:0] f3, input logic wide);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
      3'b011, 3'b110:                         return wide;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational opcode/funct decoder. Produces the control bundle,
// the store byte-lane mask, the illegal-encoding flag and the halt cause of
// a single instruction. Illegal encodings come out as an all-zero bundle
// with halt cause ILLEGAL so the register stage can load them directly.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              imm20,
  output logic              mem_to_reg,
  output logic              rd_we,
  output logic              alu_src_b,
  output logic              branch,
  output logic [1:0]        alu_op,
  output logic              rs1_in_use,
  output logic              rs2_in_use,
  output logic              pc_operand,
  output logic [XLEN/8-1:0] store_mask,
  output logic              illegal,
  output logic [1:0]        halt_cause,
  output logic              is_trap
);

  localparam int  MW   = XLEN / 8;
  localparam logic WIDE = (XLEN == 64);

  ctrl_t      c;
  logic [3:0] store_bytes;
  logic       bad;

  // Decode the opcode class, then squash everything if the encoding is bad
  always_comb begin
    c           = '0;
    store_bytes = 4'd0;
    bad         = 1'b0;
    halt_cause  = HALT_NONE;
    is_trap     = 1'b0;
    case (opcode)
      OP_R: begin
        c.rd_we      = 1'b1;
        c.rs1_in_use = 1'b1;
        c.rs2_in_use = 1'b1;
        c.alu_op     = ALU_OP_RTYPE;
        bad          = !rtype_funct7_legal(funct7);
      end
      OP_I: begin
        c.rd_we      = 1'b1;
        c.alu_src_b  = 1'b1;
        c.rs1_in_use = 1'b1;
        c.alu_op     = ALU_OP_ITYPE;
      end
      OP_LOAD: begin
        c.mem_to_reg = 1'b1;
        c.rd_we      = 1'b1;
        c.alu_src_b  = 1'b1;
        c.rs1_in_use = 1'b1;
        bad          = !load_funct3_legal(funct3, WIDE);
      end
      OP_BRANCH: begin
        c.branch     = 1'b1;
        c.alu_src_b  = 1'b1;
        c.rs1_in_use = 1'b1;
        c.rs2_in_use = 1'b1;
        c.alu_op     = ALU_OP_BRANCH;
      end
      OP_STORE: begin
        c.alu_src_b  = 1'b1;
        c.rs1_in_use = 1'b1;
        c.rs2_in_use = 1'b1;
        case (funct3)
          3'b000:  store_bytes = 4'd1;
          3'b001:  store_bytes = 4'd2;
          3'b010:  store_bytes = 4'd4;
          3'b011: begin
            if (WIDE) store_bytes = 4'd8;
            else      bad = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end
      OP_JALR: begin
        c.rd_we      = 1'b1;
        c.branch     = 1'b1;
        c.alu_src_b  = 1'b1;
        c.rs1_in_use = 1'b1;
        c.pc_operand = 1'b1;
      end
      OP_JAL: begin
        c.rd_we     = 1'b1;
        c.branch    = 1'b1;
        c.alu_src_b = 1'b1;
      end
      OP_AUIPC: begin
        c.rd_we      = 1'b1;
        c.alu_src_b  = 1'b1;
        c.pc_operand = 1'b1;
      end
      OP_LUI: begin
        c.rd_we     = 1'b1;
        c.alu_src_b = 1'b1;
      end
      OP_SYSTEM: begin
        // Only ECALL/EBREAK are implemented; CSR forms are rejected
        if (funct3 == 3'b000) begin
          is_trap    = 1'b1;
          halt_cause = imm20 ? HALT_EBREAK : HALT_ECALL;
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      c           = '0;
      store_bytes = 4'd0;
      halt_cause  = HALT_ILLEGAL;
      is_trap     = 1'b0;
    end
  end

  // Byte lanes 0..store_bytes-1 are written
  for (genvar gi = 0; gi < MW; gi++) begin : g_lane
    assign store_mask[gi] = (4'(gi) < store_bytes);
  end

  assign mem_to_reg = c.mem_to_reg;
  assign rd_we      = c.rd_we;
  assign alu_src_b  = c.alu_src_b;
  assign branch     = c.branch;
  assign alu_op     = c.alu_op;
  assign rs1_in_use = c.rs1_in_use;
  assign rs2_in_use = c.rs2_in_use;
  assign pc_operand = c.pc_operand;
  assign illegal    = bad;

endmodule

// File: rtl/ctrl_decode_stage.sv
// ID-stage control decoder: registers the decoded control bundle with one
// cycle of latency, honours stall/flush from the hazard unit, and runs a
// RUN/DRAIN/HALTED machine that turns ECALL/EBREAK into a sticky stop flag
// once the downstream pipeline has emptied.
// Optional build macro CTRL_ILLEGAL_HALT_EN: an accepted illegal instruction
// drains and halts the pipeline exactly like ECALL (halt cause ILLEGAL).
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic              imm20_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic              mem_to_reg_o,
  output logic [XLEN/8-1:0] data_mem_we_o,
  output logic              rd_we_o,
  output logic              alu_src_b_o,
  output logic              branch_o,
  output logic [1:0]        alu_2bit_op_o,
  output logic              rs1_in_use_o,
  output logic              rs2_in_use_o,
  output logic              pc_operand_o,
  output logic              illegal_o,
  output logic [1:0]        halt_cause_o,
  output logic              stop_flag_o
);

  localparam int         MW         = XLEN / 8;
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  // Combinational decode of the instruction currently in ID
  logic          dec_mem_to_reg;
  logic          dec_rd_we;
  logic          dec_alu_src_b;
  logic          dec_branch;
  logic [1:0]    dec_alu_op;
  logic          dec_rs1;
  logic          dec_rs2;
  logic          dec_pc_operand;
  logic [MW-1:0] dec_mask;
  logic          dec_illegal;
  logic [1:0]    dec_halt;
  logic          dec_trap;
  ctrl_t         dec_ctrl;

  // Registered state and outputs
  state_t        state_reg;
  logic [3:0]    cnt_reg;
  logic          first_drain_reg;
  logic          valid_reg;
  ctrl_t         ctrl_reg;
  logic [MW-1:0] mask_reg;
  logic          illegal_reg;
  logic [1:0]    halt_reg;
  logic          stop_reg;

  logic          accept;
  logic          enter_drain;

  ctrl_decode_comb #(
    .XLEN(XLEN)
  ) u_decode (
    .opcode     (opcode_i),
    .funct3     (funct3_i),
    .funct7     (funct7_i),
    .imm20      (imm20_i),
    .mem_to_reg (dec_mem_to_reg),
    .rd_we      (dec_rd_we),
    .alu_src_b  (dec_alu_src_b),
    .branch     (dec_branch),
    .alu_op     (dec_alu_op),
    .rs1_in_use (dec_rs1),
    .rs2_in_use (dec_rs2),
    .pc_operand (dec_pc_operand),
    .store_mask (dec_mask),
    .illegal    (dec_illegal),
    .halt_cause (dec_halt),
    .is_trap    (dec_trap)
  );

  assign dec_ctrl = '{
    mem_to_reg: dec_mem_to_reg,
    rd_we:      dec_rd_we,
    alu_src_b:  dec_alu_src_b,
    branch:     dec_branch,
    alu_op:     dec_alu_op,
    rs1_in_use: dec_rs1,
    rs2_in_use: dec_rs2,
    pc_operand: dec_pc_operand
  };

  // A real instruction moves into ID/EX only while running and unhindered
  assign accept = instr_valid_i & ~stall_i & ~flush_i & (state_reg == ST_RUN);

`ifdef CTRL_ILLEGAL_HALT_EN
  assign enter_drain = accept & (dec_trap | dec_illegal);
`else
  assign enter_drain = accept & dec_trap;
`endif

  // Output register, drain counter and RUN/DRAIN/HALTED state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      cnt_reg         <= 4'd0;
      first_drain_reg <= 1'b0;
      valid_reg       <= 1'b0;
      ctrl_reg        <= '0;
      mask_reg        <= '0;
      illegal_reg     <= 1'b0;
      halt_reg        <= HALT_NONE;
      stop_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (accept) begin
            valid_reg   <= 1'b1;
            ctrl_reg    <= dec_ctrl;
            mask_reg    <= dec_mask;
            illegal_reg <= dec_illegal;
            halt_reg    <= dec_halt;
            if (enter_drain) begin
              state_reg       <= ST_DRAIN;
              cnt_reg         <= DRAIN_LOAD;
              first_drain_reg <= 1'b1;
            end
          end else if (flush_i || !stall_i) begin
            // Flushed or empty slot: bubble. A plain stall keeps everything.
            valid_reg   <= 1'b0;
            ctrl_reg    <= '0;
            mask_reg    <= '0;
            illegal_reg <= 1'b0;
            halt_reg    <= HALT_NONE;
          end
        end
        ST_DRAIN: begin
          // Bubbles only; the cause stays visible while the pipe empties
          valid_reg       <= 1'b0;
          ctrl_reg        <= '0;
          mask_reg        <= '0;
          illegal_reg     <= 1'b0;
          first_drain_reg <= 1'b0;
          if (first_drain_reg && flush_i) begin
            // The trapping instruction itself was squashed: resume
            state_reg <= ST_RUN;
            halt_reg  <= HALT_NONE;
            cnt_reg   <= 4'd0;
          end else if (cnt_reg == 4'd0) begin
            state_reg <= ST_HALTED;
            stop_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_HALTED: begin
          valid_reg   <= 1'b0;
          ctrl_reg    <= '0;
          mask_reg    <= '0;
          illegal_reg <= 1'b0;
          stop_reg    <= 1'b1;
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign valid_o       = valid_reg;
  assign mem_to_reg_o  = ctrl_reg.mem_to_reg;
  assign data_mem_we_o = mask_reg;
  assign rd_we_o       = ctrl_reg.rd_we;
  assign alu_src_b_o   = ctrl_reg.alu_src_b;
  assign branch_o      = ctrl_reg.branch;
  assign alu_2bit_op_o = ctrl_reg.alu_op;
  assign rs1_in_use_o  = ctrl_reg.rs1_in_use;
  assign rs2_in_use_o  = ctrl_reg.rs2_in_use;
  assign pc_operand_o  = ctrl_reg.pc_operand;
  assign illegal_o     = illegal_reg;
  assign halt_cause_o  = halt_reg;
  assign stop_flag_o   = stop_reg;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage. Two instances share stimulus:
// an RV32 build with DRAIN_CYCLES=4 and an RV64 build with DRAIN_CYCLES=1.
// Expected bundles are pushed to a queue as stimulus is driven and popped
// after the clock edge that should register them.
module tb_ctrl_decode_stage;

  localparam logic [6:0] T_R     = 7'b0110011;
  localparam logic [6:0] T_I     = 7'b0010011;
  localparam logic [6:0] T_LOAD  = 7'b0000011;
  localparam logic [6:0] T_STORE = 7'b0100011;
  localparam logic [6:0] T_BR    = 7'b1100011;
  localparam logic [6:0] T_JAL   = 7'b1101111;
  localparam logic [6:0] T_JALR  = 7'b1100111;
  localparam logic [6:0] T_AUIPC = 7'b0010111;
  localparam logic [6:0] T_LUI   = 7'b0110111;
  localparam logic [6:0] T_SYS   = 7'b1110011;

  typedef struct packed {
    logic       valid;
    logic       mem_to_reg;
    logic [7:0] we;
    logic       rd_we;
    logic       alu_src_b;
    logic       branch;
    logic [1:0] alu_op;
    logic       rs1;
    logic       rs2;
    logic       pc_op;
    logic       illegal;
    logic [1:0] halt;
    logic       stop;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       imm20 = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;

  logic       v32, m2r32, rdwe32, srcb32, br32, rs1_32, rs2_32, pc32, ill32, stop32;
  logic [3:0] we32;
  logic [1:0] aluop32, halt32;
  logic       v64, m2r64, rdwe64, srcb64, br64, rs1_64, rs2_64, pc64, ill64, stop64;
  logic [7:0] we64;
  logic [1:0] aluop64, halt64;

  exp_t exp_q[$];
  exp_t exp64_q[$];
  exp_t got, want;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.XLEN(32), .DRAIN_CYCLES(4)) u_dut32 (
    .clk(clk), .reset(reset), .instr_valid_i(instr_valid), .opcode_i(opcode),
    .funct3_i(funct3), .funct7_i(funct7), .imm20_i(imm20), .stall_i(stall),
    .flush_i(flush), .valid_o(v32), .mem_to_reg_o(m2r32), .data_mem_we_o(we32),
    .rd_we_o(rdwe32), .alu_src_b_o(srcb32), .branch_o(br32), .alu_2bit_op_o(aluop32),
    .rs1_in_use_o(rs1_32), .rs2_in_use_o(rs2_32), .pc_operand_o(pc32),
    .illegal_o(ill32), .halt_cause_o(halt32), .stop_flag_o(stop32)
  );

  ctrl_decode_stage #(.XLEN(64), .DRAIN_CYCLES(1)) u_dut64 (
    .clk(clk), .reset(reset), .instr_valid_i(instr_valid), .opcode_i(opcode),
    .funct3_i(funct3), .funct7_i(funct7), .imm20_i(imm20), .stall_i(stall),
    .flush_i(flush), .valid_o(v64), .mem_to_reg_o(m2r64), .data_mem_we_o(we64),
    .rd_we_o(rdwe64), .alu_src_b_o(srcb64), .branch_o(br64), .alu_2bit_op_o(aluop64),
    .rs1_in_use_o(rs1_64), .rs2_in_use_o(rs2_64), .pc_operand_o(pc64),
    .illegal_o(ill64), .halt_cause_o(halt64), .stop_flag_o(stop64)
  );

  function automatic exp_t obs32();
    exp_t o;
    o = '{valid: v32, mem_to_reg: m2r32, we: {4'b0000, we32}, rd_we: rdwe32,
          alu_src_b: srcb32, branch: br32, alu_op: aluop32, rs1: rs1_32, rs2: rs2_32,
          pc_op: pc32, illegal: ill32, halt: halt32, stop: stop32};
    return o;
  endfunction

  function automatic exp_t obs64();
    exp_t o;
    o = '{valid: v64, mem_to_reg: m2r64, we: we64, rd_we: rdwe64,
          alu_src_b: srcb64, branch: br64, alu_op: aluop64, rs1: rs1_64, rs2: rs2_64,
          pc_op: pc64, illegal: ill64, halt: halt64, stop: stop64};
    return o;
  endfunction

  // Reference bundle for an instruction that is accepted while running
  function automatic exp_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic imm, input bit x64);
    exp_t e;
    bit   bad;
    e = '0;
    bad = 1'b0;
    e.valid = 1'b1;
    case (op)
      T_R: begin
        e.rd_we = 1; e.rs1 = 1; e.rs2 = 1; e.alu_op = 2'b10;
        bad = !(f7 inside {7'h00, 7'h20, 7'h01, 7'h04, 7'h05, 7'h30});
      end
      T_I:     begin e.rd_we = 1; e.alu_src_b = 1; e.rs1 = 1; e.alu_op = 2'b11; end
      T_LOAD: begin
        e.mem_to_reg = 1; e.rd_we = 1; e.alu_src_b = 1; e.rs1 = 1;
        bad = !((f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (x64 && (f3 inside {3'd3, 3'd6})));
      end
      T_BR:    begin e.branch = 1; e.alu_src_b = 1; e.rs1 = 1; e.rs2 = 1; e.alu_op = 2'b01; end
      T_STORE: begin
        e.alu_src_b = 1; e.rs1 = 1; e.rs2 = 1;
        if (f3 == 3'd0)             e.we = 8'h01;
        else if (f3 == 3'd1)        e.we = 8'h03;
        else if (f3 == 3'd2)        e.we = 8'h0F;
        else if (f3 == 3'd3 && x64) e.we = 8'hFF;
        else                        bad = 1'b1;
      end
      T_JALR:  begin e.rd_we = 1; e.branch = 1; e.alu_src_b = 1; e.rs1 = 1; e.pc_op = 1; end
      T_JAL:   begin e.rd_we = 1; e.branch = 1; e.alu_src_b = 1; end
      T_AUIPC: begin e.rd_we = 1; e.alu_src_b = 1; e.pc_op = 1; end
      T_LUI:   begin e.rd_we = 1; e.alu_src_b = 1; end
      T_SYS: begin
        if (f3 == 3'd0) e.halt = imm ? 2'b10 : 2'b01;
        else            bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      e = '0;
      e.valid = 1'b1;
      e.illegal = 1'b1;
      e.halt = 2'b11;
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic imm, input logic st, input logic fl);
    instr_valid = v; opcode = op; funct3 = f3; funct7 = f7; imm20 = imm; stall = st; flush = fl;
    $display("tx t=%0t rst=%b v=%b op=%b f3=%b f7=%b imm=%b stall=%b flush=%b",
             $time, reset, v, op, f3, f7, imm, st, fl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, T_R, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('0);
      exp64_q.push_back('0);
      tick();
      got = obs32(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL reset32[%0d]: got %h required %h", i, got, want); end
      got = obs64(); want = exp64_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL reset64[%0d]: got %h required %h", i, got, want); end
    end
    reset = 1'b0;
  endtask

  task automatic test_load();
    drive(1'b1, T_LOAD, 3'b010, 7'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ref_decode(T_LOAD, 3'b010, 7'd0, 1'b0, 1'b0));
    tick();
    got = obs32(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL lw: got %h required %h", got, want); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, T_STORE, 3'b001, 7'd0, 1'b0, 1'b1, 1'b0);
      exp_q.push_back(ref_decode(T_LOAD, 3'b010, 7'd0, 1'b0, 1'b0));
      tick();
      got = obs32(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL stall_hold[%0d]: got %h required %h", i, got, want); end
    end
    drive(1'b1, T_STORE, 3'b001, 7'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ref_decode(T_STORE, 3'b001, 7'd0, 1'b0, 1'b0));
    tick();
    got = obs32(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL sh_release: got %h required %h", got, want); end
    drive(1'b0, T_STORE, 3'b001, 7'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('0);
    tick();
    got = obs32(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL idle_bubble: got %h required %h", got, want); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      // step 1 has flush and stall together; flush must win
      drive(1'b1, T_R, 3'd0, 7'd0, 1'b0, i == 1, i == 1);
      exp_q.push_back(i == 1 ? exp_t'('0) : ref_decode(T_R, 3'd0, 7'd0, 1'b0, 1'b0));
      tick();
      got = obs32(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL flush[%0d]: got %h required %h", i, got, want); end
    end
  endtask

  task automatic test_decode_all();
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    for (int i = 0; i < 11; i++) begin
      f3 = 3'd0; f7 = 7'd0;
      case (i)
        0: op = T_I;
        1: op = T_BR;
        2: begin op = T_STORE; f3 = 3'b010; end
        3: op = T_STORE;
        4: op = T_JALR;
        5: op = T_JAL;
        6: op = T_AUIPC;
        7: op = T_LUI;
        8: begin op = T_R; f7 = 7'h01; end
        9: begin op = T_R; f7 = 7'h20; end
        default: begin op = T_LOAD; f3 = 3'b001; end
      endcase
      drive(1'b1, op, f3, f7, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(ref_decode(op, f3, f7, 1'b0, 1'b0));
      exp64_q.push_back(ref_decode(op, f3, f7, 1'b0, 1'b1));
      tick();
      got = obs32(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL decode32[%0d]: got %h required %h", i, got, want); end
      got = obs64(); want = exp64_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL decode64[%0d]: got %h required %h", i, got, want); end
    end
  endtask

  task automatic test_ecall();
    exp_t e;
    do_reset();
    drive(1'b1, T_SYS, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ref_decode(T_SYS, 3'd0, 7'd0, 1'b0, 1'b0));
    exp64_q.push_back(ref_decode(T_SYS, 3'd0, 7'd0, 1'b0, 1'b1));
    tick();
    got = obs32(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL ecall32: got %h required %h", got, want); end
    got = obs64(); want = exp64_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL ecall64: got %h required %h", got, want); end
    // Valid ADD stream; a late flush and a stall must not disturb the drain
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, T_R, 3'd0, 7'd0, 1'b0, i == 3, i == 2);
      e = '0; e.halt = 2'b01; e.stop = (i >= 4);
      exp_q.push_back(e);
      e = '0; e.halt = 2'b01; e.stop = 1'b1;
      exp64_q.push_back(e);
      tick();
      got = obs32(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL drain32[%0d]: got %h required %h", i, got, want); end
      got = obs64(); want = exp64_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL drain64[%0d]: got %h required %h", i, got, want); end
    end
    reset = 1'b1;
    drive(1'b1, T_R, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back('0);
    tick();
    got = obs32(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL halted_reset: got %h required %h", got, want); end
    reset = 1'b0;
    exp_q.push_back(ref_decode(T_R, 3'd0, 7'd0, 1'b0, 1'b0));
    tick();
    got = obs32(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL run_after_reset: got %h required %h", got, want); end
  endtask

  task automatic test_ebreak_flush();
    do_reset();
    drive(1'b1, T_SYS, 3'd0, 7'd0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(ref_decode(T_SYS, 3'd0, 7'd0, 1'b1, 1'b0));
    tick();
    got = obs32(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL ebreak: got %h required %h", got, want); end
    drive(1'b1, T_R, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back('0);
    tick();
    got = obs32(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL ebreak_flush: got %h required %h", got, want); end
    drive(1'b1, T_R, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ref_decode(T_R, 3'd0, 7'd0, 1'b0, 1'b0));
    tick();
    got = obs32(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL add_after_flush: got %h required %h", got, want); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, T_R, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
      exp_q.push_back('0);
      tick();
      got = obs32(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL no_stop[%0d]: got %h required %h", i, got, want); end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    do_reset();
    drive(1'b1, 7'b1111111, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(ref_decode(7'b1111111, 3'd0, 7'd0, 1'b0, 1'b0));
    tick();
    got = obs32(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL illegal_op: got %h required %h", got, want); end
`ifdef CTRL_ILLEGAL_HALT_EN
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, T_R, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
      e = '0; e.halt = 2'b11; e.stop = (i >= 4);
      exp_q.push_back(e);
      tick();
      got = obs32(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL illegal_drain[%0d]: got %h required %h", i, got, want); end
    end
`else
    for (int i = 0; i < 9; i++) begin
      f3 = 3'd0; f7 = 7'd0;
      case (i)
        0: op = T_R;
        1: begin op = T_LOAD;  f3 = 3'd4; end
        2: begin op = T_LOAD;  f3 = 3'd6; end
        3: begin op = T_STORE; f3 = 3'd3; end
        4: begin op = T_SYS;   f3 = 3'd1; end
        5: begin op = T_R;     f7 = 7'h21; end
        6: begin op = T_R;     f7 = 7'h30; end
        7: op = 7'd0;
        default: op = T_I;
      endcase
      drive(i != 8, op, f3, f7, 1'b0, 1'b0, 1'b0);
      e = (i == 8) ? exp_t'('0) : ref_decode(op, f3, f7, 1'b0, 1'b0);
      exp_q.push_back(e);
      tick();
      got = obs32(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL illegal_seq[%0d]: got %h required %h", i, got, want); end
    end
`endif
    do_reset();
  endtask

  task automatic test_xlen64();
    logic [6:0] op;
    logic [2:0] f3;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin op = T_STORE; f3 = 3'd3; end
        1: begin op = T_LOAD;  f3 = 3'd3; end
        2: begin op = T_LOAD;  f3 = 3'd6; end
        3: begin op = T_STORE; f3 = 3'd0; end
        default: begin op = T_STORE; f3 = 3'd4; end
      endcase
      drive(1'b1, op, f3, 7'd0, 1'b0, 1'b0, 1'b0);
      exp64_q.push_back(ref_decode(op, f3, 7'd0, 1'b0, 1'b1));
      tick();
      got = obs64(); want = exp64_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL xlen64[%0d]: got %h required %h", i, got, want); end
    end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush();
    test_decode_all();
    test_ecall();
    test_ebreak_flush();
    test_illegal();
    test_xlen64();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
Registered, parametrised control decoder for the ID stage of the rv32im_zbb pipeline. It decodes opcode, funct3 and funct7 into the ID/EX control bundle with one cycle of latency, and honours stall and flush from the hazard unit. It also detects illegal encodings. A RUN/DRAIN/HALTED state machine turns ECALL/EBREAK into a sticky stop flag, raised only after the downstream pipeline has emptied.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets the store byte-mask width to XLEN/8.
DRAIN_CYCLES, 4, cycles between accepting ECALL/EBREAK and asserting stop_flag_o; legal range 1..15.

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  synchronous, active-high reset
instr_valid_i  in  1  ID holds a real instruction
opcode_i  in  7  instruction[6:0]
funct3_i  in  3  instruction[14:12]
funct7_i  in  7  instruction[31:25]
imm20_i  in  1  instruction[20]; 0 = ECALL, 1 = EBREAK
stall_i  in  1  hold output register
flush_i  in  1  squash the instruction being registered
valid_o  out  1  registered control bundle is a real instruction
mem_to_reg_o  out  1  writeback selects load data
data_mem_we_o  out  XLEN/8  store byte-lane write enables
rd_we_o  out  1  register-file write enable
alu_src_b_o  out  1  ALU operand B: 0 = rs2, 1 = imm
branch_o  out  1  B-type, JAL or JALR
alu_2bit_op_o  out  2  00 = add (ld/st/jumps/U-type), 01 = branch compare, 10 = R-type, 11 = I-type ALU
rs1_in_use_o  out  1  rs1 is read
rs2_in_use_o  out  1  rs2 is read
pc_operand_o  out  1  operand A = PC (AUIPC, JALR)
illegal_o  out  1  registered instruction was illegal
halt_cause_o  out  2  00 none, 01 ECALL, 10 EBREAK, 11 illegal
stop_flag_o  out  1  program finished; sticky

Behaviour:
- Reset: every output is 0 (halt_cause_o = 00) and the state is RUN.
- Latency: the decoded bundle appears on the edge after the instruction is presented. Outputs are driven only from registers.
- Accept condition: instr_valid_i & ~stall_i & ~flush_i & state==RUN.
- Register update precedence, highest first: reset > flush_i (load bubble) > stall_i (hold all outputs) > load decode result.
- A cycle that is not accepted and not stalled loads a bubble.
- Bubble definition: all control outputs 0 and valid_o = 0.
- Decode values per opcode:
  - R-type: rd_we, rs1, rs2; alu op 10.
  - I-type ALU: rd_we, alu_src_b, rs1; alu op 11.
  - Load: mem_to_reg, rd_we, alu_src_b, rs1; alu op 00.
  - B-type: branch, alu_src_b, rs1, rs2; alu op 01.
  - Store: alu_src_b, rs1, rs2; alu op 00.
  - JALR: rd_we, branch, alu_src_b, rs1, pc_operand.
  - JAL: rd_we, branch, alu_src_b.
  - AUIPC: rd_we, alu_src_b, pc_operand.
  - LUI: rd_we, alu_src_b.
- Store mask by funct3:
  - 000 = 0x1, 001 = 0x3, 010 = 0xF.
  - 011 = 0xFF, legal only when XLEN = 64.
  - Any other funct3 is illegal.
- Legal load funct3: 000, 001, 010, 100, 101. When XLEN = 64, 011 and 110 are also legal.
- R-type legal funct7: 0000000, 0100000, 0000001 (M), 0000100, 0000101, 0110000 (Zbb).
- Illegal instruction:
  - Triggers: any unknown opcode, any funct3/funct7 violation above, or SYSTEM opcode with funct3 ≠ 000.
  - Result: a bubble with valid_o = 1, illegal_o = 1, halt_cause_o = 11.
  - illegal_o is held for one accepted cycle only; the next load clears it.
- SYSTEM opcode 1110011 with funct3 = 000:
  - Registered as valid_o = 1, all write enables 0, halt_cause_o = 01 (imm20_i = 0) or 10 (imm20_i = 1).
  - State goes RUN → DRAIN and the counter loads DRAIN_CYCLES-1.
- State machine:
  - RUN: normal decode.
  - DRAIN: every cycle loads a bubble, regardless of inputs. The counter decrements every cycle, including stalled cycles. At counter = 0 the state goes to HALTED.
  - HALTED: stop_flag_o = 1; outputs are bubbles. The state is left only by reset.
- flush_i in the first DRAIN cycle (the ECALL is still in the output register and is squashed): return to RUN and clear halt_cause_o. Later flushes do not affect DRAIN.
- With DRAIN_CYCLES = 1, HALTED is reached on the edge after ECALL is registered.
- Reset asserted in any state returns to RUN with all outputs 0 on the next edge.
- halt_cause_o holds its last non-zero cause while in HALTED.

Optional Feature:
- Macro: CTRL_ILLEGAL_HALT_EN.
- When defined: an accepted illegal instruction enters DRAIN exactly like ECALL and ends in HALTED with halt_cause_o = 11.
- When undefined: illegal_o pulses, and decoding continues in RUN.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, OP_SYSTEM);
  - ALU_OP_* 2-bit encodings;
  - HALT_* cause codes;
  - the RUN/DRAIN/HALTED state encoding.
- One sub-module: ctrl_decode_comb, a purely combinational opcode/funct → bundle + illegal decoder parametrised by XLEN. The top level holds the output register, the FSM and the drain counter.

Test Plan:
- Reset for 2 cycles, then LW (opcode 0000011, funct3 010) valid → one cycle later valid_o=1, mem_to_reg_o=1, rd_we_o=1, alu_src_b_o=1, alu_2bit_op_o=00, data_mem_we_o=0.
- SH with stall_i=1 for 3 cycles, then released → outputs hold the previous bundle during the stall; data_mem_we_o=0x3 one cycle after release. XLEN=64 SD → 0xFF.
- ADD registered, then flush_i=1 with stall_i=1 → next cycle valid_o=0, all enables 0 (flush beats stall).
- ECALL accepted, DRAIN_CYCLES=4, followed by a valid ADD stream → halt_cause_o=01; the following cycles are bubbles; stop_flag_o rises 4 edges after ECALL is registered and stays high until reset.
- EBREAK registered, flush_i in the next cycle → state returns to RUN, halt_cause_o=00, stop_flag_o never rises; a subsequent ADD decodes normally.
- Opcode 1111111 → illegal_o=1, halt_cause_o=11 for one cycle. Without CTRL_ILLEGAL_HALT_EN decoding continues; with it, stop_flag_o asserts after DRAIN_CYCLES.
